// File: rtl/modulator_pkg.sv
// Shared types and constants for the OFDM modulator datapath.
// Holds the scheduler state encoding, subcarrier bin classes and default band/pilot settings.
package modulator_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    WAIT_DATA
  } state_t;

  typedef enum logic [1:0] {
    CLS_NULL,
    CLS_PILOT,
    CLS_DATA
  } bin_cls_t;

  localparam int GUARD_LO_DEFAULT = 400;
  localparam int GUARD_HI_DEFAULT = 623;

  localparam logic [31:0] PILOT_VALUE = 32'h0000_7fff;

endpackage

// File: rtl/subcarrier_classifier.sv
// Classifies subcarrier index k as NULL / PILOT / DATA.
// Owns the active-bin counter that spaces pilots evenly across the active bins of a symbol.
module subcarrier_classifier
  import modulator_pkg::*;
#(
  parameter int FFT_SIZE = 1024,
  parameter int IDX_W    = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             step,
  input  logic [IDX_W-1:0] k,
  input  logic [IDX_W-1:0] guard_lo,
  input  logic [IDX_W-1:0] guard_hi,
  input  logic [7:0]       pilot_spacing,
  output bin_cls_t         cls
);

  localparam logic [IDX_W-1:0] K_LAST = IDX_W'(FFT_SIZE - 1);

  logic [7:0] pcnt_reg;
  logic [7:0] pcnt_next;
  logic       is_null;
  logic       is_pilot;

  always_comb begin
    is_null  = (k == '0) || (k == K_LAST) || ((k > guard_lo) && (k < guard_hi));
    is_pilot = (pilot_spacing != 8'd0) && (pcnt_reg == (pilot_spacing - 8'd1));
    cls      = is_null ? CLS_NULL : (is_pilot ? CLS_PILOT : CLS_DATA);

    // The counter restarts for every symbol, so it is cleared as the last bin is consumed.
    pcnt_next = pcnt_reg;
    if (k == K_LAST) begin
      pcnt_next = '0;
    end else if (!is_null) begin
      pcnt_next = is_pilot ? 8'd0 : (pcnt_reg + 8'd1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcnt_reg <= '0;
    end else if (clear) begin
      pcnt_reg <= '0;
    end else if (step) begin
      pcnt_reg <= pcnt_next;
    end
  end

endmodule

// File: rtl/subcarrier_scheduler.sv
// Walks the subcarriers of each OFDM symbol in a burst and streams NULL, pilot or FIFO data
// toward the IFFT, with tlast on the last bin and tuser marking the final symbol.
module subcarrier_scheduler #(
  parameter int                    FFT_SIZE    = 1024,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    IDX_W       = 10,
  parameter int                    SYM_W       = 16,
  parameter logic [DATA_WIDTH-1:0] PILOT_VALUE = DATA_WIDTH'(modulator_pkg::PILOT_VALUE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reset_mod,
  input  logic                  start,
  input  logic [IDX_W-1:0]      cfg_guard_lo,
  input  logic [IDX_W-1:0]      cfg_guard_hi,
  input  logic [7:0]            cfg_pilot_spacing,
  input  logic [SYM_W-1:0]      cfg_num_symbols,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_tlast,
  output logic                  m_tuser,
  output logic                  busy,
  output logic                  underrun,
  output logic                  cfg_err,
  output logic [SYM_W-1:0]      sym_count
);

  import modulator_pkg::*;

  localparam logic [IDX_W-1:0] K_LAST = IDX_W'(FFT_SIZE - 1);

  state_t                state_reg, state_next;
  logic [IDX_W-1:0]      k_reg, k_next;
  logic [SYM_W-1:0]      sym_count_reg, sym_count_next;
  logic [SYM_W-1:0]      load_sym_reg, load_sym_next;
  logic                  m_valid_reg, m_valid_next;
  logic [DATA_WIDTH-1:0] m_data_reg, m_data_next;
  logic                  m_tlast_reg, m_tlast_next;
  logic                  m_tuser_reg, m_tuser_next;
  logic                  underrun_reg, underrun_next;
  logic                  cfg_err_reg, cfg_err_next;
  logic [IDX_W-1:0]      guard_lo_reg, guard_lo_next;
  logic [IDX_W-1:0]      guard_hi_reg, guard_hi_next;
  logic [7:0]            spacing_reg, spacing_next;
  logic [SYM_W-1:0]      num_sym_reg, num_sym_next;

  bin_cls_t              cls;
  logic                  advance;
  logic                  cfg_ok;
  logic                  final_beat;
  logic                  last_k;
  logic                  load_tuser;
  logic                  load_en;
  logic [DATA_WIDTH-1:0] load_val;
  logic                  start_ok;

  subcarrier_classifier #(
    .FFT_SIZE (FFT_SIZE),
    .IDX_W    (IDX_W)
  ) u_classifier (
    .clk           (clk),
    .rst           (rst),
    .clear         (start_ok || reset_mod),
    .step          (load_en),
    .k             (k_reg),
    .guard_lo      (guard_lo_reg),
    .guard_hi      (guard_hi_reg),
    .pilot_spacing (spacing_reg),
    .cls           (cls)
  );

  always_comb begin
    advance    = !m_valid_reg || m_ready;
    cfg_ok     = (cfg_guard_lo != '0) && (cfg_guard_lo < cfg_guard_hi) && (cfg_guard_hi <= K_LAST);
    final_beat = m_valid_reg && m_tlast_reg && m_tuser_reg;
    last_k     = (k_reg == K_LAST);
    // load_sym_reg tracks the symbol being loaded, which runs ahead of the emitted count.
    load_tuser = (num_sym_reg != '0) && ((load_sym_reg + SYM_W'(1)) == num_sym_reg);

    state_next     = state_reg;
    k_next         = k_reg;
    sym_count_next = sym_count_reg;
    load_sym_next  = load_sym_reg;
    m_valid_next   = m_valid_reg;
    m_data_next    = m_data_reg;
    m_tlast_next   = m_tlast_reg;
    m_tuser_next   = m_tuser_reg;
    guard_lo_next  = guard_lo_reg;
    guard_hi_next  = guard_hi_reg;
    spacing_next   = spacing_reg;
    num_sym_next   = num_sym_reg;
    underrun_next  = 1'b0;
    cfg_err_next   = 1'b0;
    s_ready        = 1'b0;
    start_ok       = 1'b0;
    load_en        = 1'b0;
    load_val       = '0;

    if (m_valid_reg && m_ready && m_tlast_reg) begin
      sym_count_next = sym_count_reg + SYM_W'(1);
    end

    case (state_reg)
      IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            // Bin 0 is always NULL, so the first beat is produced directly from the start.
            start_ok       = 1'b1;
            state_next     = RUN;
            k_next         = IDX_W'(1);
            sym_count_next = '0;
            load_sym_next  = '0;
            m_valid_next   = 1'b1;
            m_data_next    = '0;
            m_tlast_next   = 1'b0;
            m_tuser_next   = (cfg_num_symbols == SYM_W'(1));
            guard_lo_next  = cfg_guard_lo;
            guard_hi_next  = cfg_guard_hi;
            spacing_next   = cfg_pilot_spacing;
            num_sym_next   = cfg_num_symbols;
          end else begin
            cfg_err_next = 1'b1;
          end
        end
      end

      RUN: begin
        if (final_beat) begin
          if (m_ready) begin
            state_next   = IDLE;
            m_valid_next = 1'b0;
            m_tlast_next = 1'b0;
            m_tuser_next = 1'b0;
          end
        end else if (advance) begin
          case (cls)
            CLS_NULL: load_en = 1'b1;
            CLS_PILOT: begin
              load_en  = 1'b1;
              load_val = PILOT_VALUE;
            end
            default: begin
              s_ready = 1'b1;
              if (s_valid) begin
                load_en  = 1'b1;
                load_val = s_data;
              end else begin
                m_valid_next  = 1'b0;
                m_tlast_next  = 1'b0;
                m_tuser_next  = 1'b0;
                state_next    = WAIT_DATA;
                underrun_next = 1'b1;
              end
            end
          endcase
        end
      end

      WAIT_DATA: begin
        if (cls == CLS_DATA) begin
          s_ready = advance;
          if (advance && s_valid) begin
            load_en    = 1'b1;
            load_val   = s_data;
            state_next = RUN;
          end
        end
      end

      default: state_next = IDLE;
    endcase

    if (load_en) begin
      m_valid_next = 1'b1;
      m_data_next  = load_val;
      m_tlast_next = last_k;
      m_tuser_next = load_tuser;
      k_next       = k_reg + IDX_W'(1);
      if (last_k) begin
        load_sym_next = load_sym_reg + SYM_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      k_reg         <= '0;
      sym_count_reg <= '0;
      load_sym_reg  <= '0;
      m_valid_reg   <= 1'b0;
      m_data_reg    <= '0;
      m_tlast_reg   <= 1'b0;
      m_tuser_reg   <= 1'b0;
      underrun_reg  <= 1'b0;
      cfg_err_reg   <= 1'b0;
      guard_lo_reg  <= '0;
      guard_hi_reg  <= '0;
      spacing_reg   <= '0;
      num_sym_reg   <= '0;
    end else if (reset_mod) begin
      state_reg     <= IDLE;
      k_reg         <= '0;
      sym_count_reg <= '0;
      load_sym_reg  <= '0;
      m_valid_reg   <= 1'b0;
      m_data_reg    <= '0;
      m_tlast_reg   <= 1'b0;
      m_tuser_reg   <= 1'b0;
      underrun_reg  <= 1'b0;
      cfg_err_reg   <= 1'b0;
      guard_lo_reg  <= '0;
      guard_hi_reg  <= '0;
      spacing_reg   <= '0;
      num_sym_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      k_reg         <= k_next;
      sym_count_reg <= sym_count_next;
      load_sym_reg  <= load_sym_next;
      m_valid_reg   <= m_valid_next;
      m_data_reg    <= m_data_next;
      m_tlast_reg   <= m_tlast_next;
      m_tuser_reg   <= m_tuser_next;
      underrun_reg  <= underrun_next;
      cfg_err_reg   <= cfg_err_next;
      guard_lo_reg  <= guard_lo_next;
      guard_hi_reg  <= guard_hi_next;
      spacing_reg   <= spacing_next;
      num_sym_reg   <= num_sym_next;
    end
  end

  assign m_valid   = m_valid_reg;
  assign m_data    = m_data_reg;
  assign m_tlast   = m_tlast_reg;
  assign m_tuser   = m_tuser_reg;
  assign busy      = (state_reg != IDLE);
  assign underrun  = underrun_reg;
  assign cfg_err   = cfg_err_reg;
  assign sym_count = sym_count_reg;

endmodule

// File: tb/tb_subcarrier_scheduler.sv
// Self-checking bench for subcarrier_scheduler: randomized FIFO words and backpressure,
// with expected beats derived from the subcarrier classification rules.
module tb_subcarrier_scheduler;

  localparam int N      = 1024;
  localparam int MEM_SZ = 8192;
  localparam int LIMIT  = 20000;
  localparam logic [31:0] PILOT = 32'h0000_7fff;
  localparam int GLO = modulator_pkg::GUARD_LO_DEFAULT;
  localparam int GHI = modulator_pkg::GUARD_HI_DEFAULT;

  logic        clk;
  logic        rst;
  logic        reset_mod;
  logic        start;
  logic [9:0]  cfg_guard_lo;
  logic [9:0]  cfg_guard_hi;
  logic [7:0]  cfg_pilot_spacing;
  logic [15:0] cfg_num_symbols;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_tlast;
  logic        m_tuser;
  logic        busy;
  logic        underrun;
  logic        cfg_err;
  logic [15:0] sym_count;

  subcarrier_scheduler dut (
    .clk               (clk),
    .rst               (rst),
    .reset_mod         (reset_mod),
    .start             (start),
    .cfg_guard_lo      (cfg_guard_lo),
    .cfg_guard_hi      (cfg_guard_hi),
    .cfg_pilot_spacing (cfg_pilot_spacing),
    .cfg_num_symbols   (cfg_num_symbols),
    .s_valid           (s_valid),
    .s_ready           (s_ready),
    .s_data            (s_data),
    .m_valid           (m_valid),
    .m_ready           (m_ready),
    .m_data            (m_data),
    .m_tlast           (m_tlast),
    .m_tuser           (m_tuser),
    .busy              (busy),
    .underrun          (underrun),
    .cfg_err           (cfg_err),
    .sym_count         (sym_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] fifo_mem [MEM_SZ];
  int          rd_idx = 0;

  logic [31:0] got_data [$];
  logic        got_last [$];
  logic        got_user [$];
  logic [31:0] exp_data [$];
  logic        exp_last [$];
  logic        exp_user [$];

  int pops, underruns, stalls, unstable, first_valid;
  bit timed_out;

  // Reference: walk every bin of every symbol using the classification rules directly.
  task automatic build_expected(input int lo, input int hi, input int sp, input int nsym, input int base);
    int n = 0;
    exp_data.delete(); exp_last.delete(); exp_user.delete();
    for (int s = 0; s < nsym; s++) begin
      int active = 0;
      for (int k = 0; k < N; k++) begin
        logic [31:0] d;
        if (k == 0 || k == N - 1 || (k > lo && k < hi)) begin
          d = 32'h0;
        end else begin
          if (sp != 0 && (active % sp) == sp - 1) d = PILOT;
          else begin d = fifo_mem[(base + n) % MEM_SZ]; n++; end
          active++;
        end
        exp_data.push_back(d);
        exp_last.push_back(k == N - 1);
        exp_user.push_back(s == nsym - 1);
      end
    end
  endtask

  // Drives one burst; sv_mode 1 withholds FIFO data for 5 cycles after the 9th pop.
  task automatic run_burst(input int lo, input int hi, input int sp, input int nsym,
                           input int sv_mode, input int rdy_mode);
    int drop_left = 0;
    bit dropped = 0;
    bit prev_hold = 0;
    bit done = 0;
    logic [31:0] prev_data = '0;
    got_data.delete(); got_last.delete(); got_user.delete();
    pops = 0; underruns = 0; stalls = 0; unstable = 0; first_valid = -1;
    @(negedge clk);
    cfg_guard_lo = 10'(lo); cfg_guard_hi = 10'(hi);
    cfg_pilot_spacing = 8'(sp); cfg_num_symbols = 16'(nsym);
    start = 1'b1; m_ready = 1'b1; s_valid = 1'b1; s_data = fifo_mem[rd_idx % MEM_SZ];
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < LIMIT; c++) begin
      if (c > 0) @(negedge clk);
      m_ready = (rdy_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (sv_mode == 1 && !dropped && pops == 9) begin drop_left = 5; dropped = 1; end
      s_valid = (drop_left == 0);
      if (drop_left > 0) drop_left--;
      s_data = fifo_mem[rd_idx % MEM_SZ];
      #1;
      if (prev_hold && (!m_valid || m_data !== prev_data)) unstable++;
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
      if (first_valid < 0 && m_valid) first_valid = c;
      if (busy && !m_valid) stalls++;
      if (underrun) underruns++;
      if (m_valid && m_ready) begin
        got_data.push_back(m_data); got_last.push_back(m_tlast); got_user.push_back(m_tuser);
      end
      if (s_valid && s_ready) begin pops++; rd_idx++; end
      if (!busy && !m_valid) begin done = 1; break; end
    end
    timed_out = !done;
    m_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; reset_mod = 1'b0; start = 1'b0; s_valid = 1'b0; m_ready = 1'b1; s_data = '0;
    cfg_guard_lo = '0; cfg_guard_hi = '0; cfg_pilot_spacing = '0; cfg_num_symbols = '0;
    for (int i = 0; i < MEM_SZ; i++) fifo_mem[i] = $urandom() | 32'h1;
    repeat (3) @(negedge clk);
    #1;
    tests_run++;
    if ({m_valid, m_tlast, m_tuser, busy, underrun, cfg_err, s_ready} !== 7'b0) begin
      tests_failed++;
      $display("FAIL reset_flags got=%b need=0000000", {m_valid, m_tlast, m_tuser, busy, underrun, cfg_err, s_ready});
    end
    tests_run++;
    if (m_data !== 32'h0 || sym_count !== 16'h0) begin
      tests_failed++;
      $display("FAIL reset_data got m_data=%h sym_count=%0d need 0/0", m_data, sym_count);
    end
    @(negedge clk); rst = 1'b1;
    $display("[TB] reset checked");
  endtask

  task automatic test_default_burst();
    int nerr = 0; int first_bad = -1;
    build_expected(GLO, GHI, 0, 1, rd_idx);
    run_burst(GLO, GHI, 0, 1, 0, 0);
    tests_run++;
    if (timed_out || got_data.size() != N) begin
      tests_failed++;
      $display("FAIL default_beats got=%0d need=%0d timeout=%0b", got_data.size(), N, timed_out);
    end
    for (int i = 0; i < got_data.size() && i < exp_data.size(); i++)
      if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i] || got_user[i] !== exp_user[i]) begin
        if (first_bad < 0) first_bad = i;
        nerr++;
      end
    tests_run++;
    if (nerr != 0) begin
      tests_failed++;
      $display("FAIL default_seq %0d bad beats, first at %0d got=%h/%b need=%h/%b", nerr, first_bad,
               got_data[first_bad], got_last[first_bad], exp_data[first_bad], exp_last[first_bad]);
    end
    tests_run++;
    if (pops != 800) begin tests_failed++; $display("FAIL default_pops got=%0d need=800", pops); end
    tests_run++;
    if (first_valid != 0) begin tests_failed++; $display("FAIL default_latency got=%0d need=0", first_valid); end
    tests_run++;
    if (busy !== 1'b0 || sym_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL default_end got busy=%b sym_count=%0d need 0/1", busy, sym_count);
    end
    $display("[TB] default burst: %0d beats, %0d pops", got_data.size(), pops);
  endtask

  task automatic test_pilots();
    int nerr = 0; int first_bad = -1;
    build_expected(GLO, GHI, 8, 2, rd_idx);
    run_burst(GLO, GHI, 8, 2, 0, 0);
    for (int i = 0; i < got_data.size() && i < exp_data.size(); i++)
      if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i] || got_user[i] !== exp_user[i]) begin
        if (first_bad < 0) first_bad = i;
        nerr++;
      end
    tests_run++;
    if (timed_out || got_data.size() != 2 * N || nerr != 0) begin
      tests_failed++;
      $display("FAIL pilot_seq got %0d beats (%0d bad, first %0d) need %0d beats", got_data.size(), nerr, first_bad, 2 * N);
    end
    tests_run++;
    if (pops != 1400) begin tests_failed++; $display("FAIL pilot_pops got=%0d need=1400", pops); end
    tests_run++;
    if (sym_count !== 16'd2) begin tests_failed++; $display("FAIL pilot_symcount got=%0d need=2", sym_count); end
    $display("[TB] pilot burst: %0d beats, %0d pops, sym_count=%0d", got_data.size(), pops, sym_count);
  endtask

  task automatic test_underrun();
    int nerr = 0; int first_bad = -1;
    build_expected(GLO, GHI, 0, 1, rd_idx);
    run_burst(GLO, GHI, 0, 1, 1, 0);
    for (int i = 0; i < got_data.size() && i < exp_data.size(); i++)
      if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
        if (first_bad < 0) first_bad = i;
        nerr++;
      end
    tests_run++;
    if (timed_out || got_data.size() != N || nerr != 0) begin
      tests_failed++;
      $display("FAIL underrun_seq got %0d beats (%0d bad, first %0d) need %0d", got_data.size(), nerr, first_bad, N);
    end
    tests_run++;
    if (underruns != 1) begin tests_failed++; $display("FAIL underrun_pulses got=%0d need=1", underruns); end
    tests_run++;
    if (stalls != 5) begin tests_failed++; $display("FAIL underrun_stall got=%0d need=5", stalls); end
    tests_run++;
    if (pops != 800) begin tests_failed++; $display("FAIL underrun_pops got=%0d need=800", pops); end
    $display("[TB] underrun burst: %0d pulses, %0d stall cycles", underruns, stalls);
  endtask

  task automatic test_backpressure();
    int nerr = 0; int first_bad = -1;
    build_expected(GLO, GHI, 8, 2, rd_idx);
    run_burst(GLO, GHI, 8, 2, 0, 1);
    for (int i = 0; i < got_data.size() && i < exp_data.size(); i++)
      if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i] || got_user[i] !== exp_user[i]) begin
        if (first_bad < 0) first_bad = i;
        nerr++;
      end
    tests_run++;
    if (timed_out || got_data.size() != 2 * N || nerr != 0) begin
      tests_failed++;
      $display("FAIL backpressure_seq got %0d beats (%0d bad, first %0d) need %0d", got_data.size(), nerr, first_bad, 2 * N);
    end
    tests_run++;
    if (unstable != 0) begin tests_failed++; $display("FAIL backpressure_hold got=%0d changes need=0", unstable); end
    tests_run++;
    if (pops != 1400) begin tests_failed++; $display("FAIL backpressure_pops got=%0d need=1400", pops); end
    $display("[TB] backpressure burst: %0d beats, %0d pops", got_data.size(), pops);
  endtask

  task automatic test_cfg_err();
    int bad_lo [2] = '{600, 0};
    int bad_hi [2] = '{500, 500};
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      cfg_guard_lo = 10'(bad_lo[t]); cfg_guard_hi = 10'(bad_hi[t]);
      cfg_pilot_spacing = 8'd0; cfg_num_symbols = 16'd1; start = 1'b1;
      @(negedge clk); start = 1'b0;
      #1;
      tests_run++;
      if (cfg_err !== 1'b1 || busy !== 1'b0 || m_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL cfg_err_pulse lo=%0d hi=%0d got err/busy/valid=%b%b%b need 100",
                 bad_lo[t], bad_hi[t], cfg_err, busy, m_valid);
      end
      @(negedge clk); #1;
      tests_run++;
      if (cfg_err !== 1'b0 || busy !== 1'b0 || m_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL cfg_err_after lo=%0d hi=%0d got err/busy/valid=%b%b%b need 000",
                 bad_lo[t], bad_hi[t], cfg_err, busy, m_valid);
      end
      $display("[TB] rejected start lo=%0d hi=%0d", bad_lo[t], bad_hi[t]);
    end
  endtask

  task automatic test_reset_mod();
    int beats = 0; int nerr = 0;
    @(negedge clk);
    cfg_guard_lo = 10'(GLO); cfg_guard_hi = 10'(GHI); cfg_pilot_spacing = 8'd0; cfg_num_symbols = 16'd2;
    start = 1'b1; m_ready = 1'b1; s_valid = 1'b1; s_data = fifo_mem[rd_idx % MEM_SZ];
    @(negedge clk); start = 1'b0;
    for (int c = 0; c < LIMIT && beats < 300; c++) begin
      if (c > 0) @(negedge clk);
      s_data = fifo_mem[rd_idx % MEM_SZ];
      #1;
      if (m_valid && m_ready) beats++;
      if (s_valid && s_ready) rd_idx++;
    end
    @(negedge clk); reset_mod = 1'b1;
    @(negedge clk); reset_mod = 1'b0;
    #1;
    tests_run++;
    if ({m_valid, m_tlast, m_tuser, busy, underrun} !== 5'b0 || m_data !== 32'h0 || sym_count !== 16'h0) begin
      tests_failed++;
      $display("FAIL reset_mod_clear got flags=%b m_data=%h sym=%0d need 00000/0/0",
               {m_valid, m_tlast, m_tuser, busy, underrun}, m_data, sym_count);
    end
    build_expected(GLO, GHI, 4, 1, rd_idx);
    run_burst(GLO, GHI, 4, 1, 0, 0);
    for (int i = 0; i < got_data.size() && i < exp_data.size(); i++)
      if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) nerr++;
    tests_run++;
    if (timed_out || got_data.size() != N || nerr != 0 || sym_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL reset_mod_restart got %0d beats (%0d bad) sym=%0d need %0d beats sym=1",
               got_data.size(), nerr, sym_count, N);
    end
    $display("[TB] reset_mod after %0d beats, restart gave %0d beats", beats, got_data.size());
  endtask

  task automatic test_async_reset();
    logic [31:0] word;
    word = fifo_mem[rd_idx % MEM_SZ];
    @(negedge clk);
    cfg_guard_lo = 10'(GLO); cfg_guard_hi = 10'(GHI); cfg_pilot_spacing = 8'd0; cfg_num_symbols = 16'd0;
    start = 1'b1; m_ready = 1'b1; s_valid = 1'b1; s_data = word;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    tests_run++;
    if (m_valid !== 1'b1 || m_data !== word || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL async_pre got valid=%b data=%h busy=%b need 1/%h/1", m_valid, m_data, busy, word);
    end
    #1 rst = 1'b0;
    #1;
    tests_run++;
    if (m_valid !== 1'b0 || m_data !== 32'h0 || busy !== 1'b0 || s_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_clear got valid=%b data=%h busy=%b s_ready=%b need 0/0/0/0", m_valid, m_data, busy, s_ready);
    end
    @(negedge clk); rst = 1'b1;
    $display("[TB] async reset mid-burst");
  endtask

  initial begin
    test_reset();
    test_default_burst();
    test_pilots();
    test_underrun();
    test_backpressure();
    test_cfg_err();
    test_reset_mod();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
